initialization_command_word_sequencer: RTL
==========================================

// Module: initialization_command_word_sequencer
// PURPOSE
//  Clocked, parametrised ICW1-ICW4 sequencer for the 8259A control logic; supersedes the combinational ICW1 latch.
//  Decodes CPU writes from the bus buffer (A0 + internal_data_bus), steps through ICW1..ICW4 and holds all config registers.
//  Flags completion and emits one-cycle OCW1/2/3 strobes once initialized.
//  Feeds the interrupt mask, priority resolver, cascade and vector logic.
// PARAMETERS
//  CASCADE_LINES   8  ICW3 width used (1..8); data bits above it ignored, cascade_device_config zero-extended.
//  SUPPORT_ICW4    1  0: IC4 ignored, ICW4 never expected, ICW4 fields held at 0.
// PORTS
//  clock                                input   1   single clock; everything samples on rising edge
//  reset                                input   1   synchronous, active-high
//  write_strobe                         input   1   one-cycle pulse per CPU write
//  address_a0                           input   1   A0 of the write
//  internal_data_bus                    input   8   write data
//  interrupt_vector_address             output  11  {ICW2[7:0], ICW1[7:5]}
//  level_or_edge_triggered_config       output  1   ICW1 D3 (LTIM)
//  call_address_interval_4_or_8_config  output  1   ICW1 D2 (ADI)
//  single_or_cascade_config             output  1   ICW1 D1 (SNGL)
//  set_icw4_config                      output  1   ICW1 D0 (IC4), forced 0 if !SUPPORT_ICW4
//  cascade_device_config                output  8   ICW3 (master: slave bitmap; slave: ID in [2:0])
//  special_fully_nest_config            output  1   ICW4 D4
//  buffered_mode_config                 output  1   ICW4 D3
//  buffered_master_or_slave_config      output  1   ICW4 D2
//  auto_eoi_config                      output  1   ICW4 D1
//  u8086_or_mcs80_config                output  1   ICW4 D0
//  initialization_start                 output  1   pulse: ICW1 accepted (clear IMR/edge latches)
//  initialization_complete              output  1   level: sequence finished, OCWs accepted
//  write_operation_control_word_1/2/3   output  1   each a one-cycle pulse
// BEHAVIOUR
//  Reset: all outputs 0, state UNINIT. Reset overrides a same-cycle write_strobe.
//  All outputs are registered: an accepted write changes outputs on the next rising edge (latency 1).
//  ICW1 = strobe & !A0 & D4. Accepted in ANY state; restarts the sequence.
//   Loads ICW1 fields and vector[2:0]; clears vector[10:3], ICW3 and all ICW4 fields.
//   Pulses initialization_start, drops initialization_complete, goes to WAIT_ICW2.
//  States: UNINIT, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY.
//   WAIT_ICW2 + strobe&A0: load vector[10:3] = data. Next state WAIT_ICW3 if SNGL=0, else WAIT_ICW4 if IC4, else READY.
//   WAIT_ICW3 + strobe&A0: load ICW3 (low CASCADE_LINES bits). Next state WAIT_ICW4 if IC4, else READY.
//   WAIT_ICW4 + strobe&A0: load data[4:0] into ICW4 fields, then READY.
//   Entering READY sets initialization_complete in that same edge.
//   Non-ICW1 writes with A0=0 in WAIT_* states are ignored: no state or config change, no pulse.
//  UNINIT: only ICW1 has effect; all other writes are ignored.
//  READY decode (OCW strobes):
//   A0=1 -> OCW1 pulse.
//   A0=0, D4=0, D3=0 -> OCW2 pulse.
//   A0=0, D4=0, D3=1 -> OCW3 pulse.
//   Exactly one pulse per accepted write; never more than one strobe high at once.
//  Back-to-back strobes on consecutive cycles are each processed. There is no busy stall.
//  Reset mid-sequence: UNINIT, all config cleared, no OCW pulse.
// STRUCTURE
//  State encodings and ICW/OCW bit positions go in shared constants include pic_8259a_defines.vh, for reuse by the OCW block.
//  Single module, no sub-module: the next-state decode and config register file are small and tightly coupled.
// TESTING
//  Single mode: ICW1=8'h13, ICW2=8'h20, ICW4=8'h01 -> vector=11'h100, SNGL=1, u8086=1, complete=1 one edge after the ICW4 write; ICW3 skipped.
//  Cascade mode: ICW1=8'h11, ICW2=8'h40, ICW3=8'h04, ICW4=8'h1D -> cascade_device_config=8'h04, SFNM=1, BUF=1, M/S=1, AEOI=0, u8086=1.
//  No ICW4: ICW1=8'h12, ICW2=8'h08 -> READY right after ICW2, all ICW4 fields 0. The next A0=1 write pulses only OCW1.
//  Restart: ICW1 then ICW2, then ICW1=8'h1B mid-sequence -> initialization_start pulses, vector[10:3]=0, state WAIT_ICW2, complete=0.
//  READY decode: writes 8'h20@A0=0, 8'h0B@A0=0, 8'hFF@A0=1 -> OCW2, OCW3, OCW1 pulses on successive edges, config unchanged.
//  Reset: assert reset together with write_strobe while in WAIT_ICW4 -> all outputs 0 next edge; A0=1 writes then ignored until an ICW1.

Source files
------------

// File: rtl/initialization_command_word_sequencer_pkg.sv
// Shared definitions for the 8259A ICW sequencer and the OCW block:
// sequence state encoding, ICW/OCW bit positions and the cascade mask helper.
package initialization_command_word_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_UNINIT    = 3'd0,
      ST_WAIT_ICW2 = 3'd1,
      ST_WAIT_ICW3 = 3'd2,
      ST_WAIT_ICW4 = 3'd3,
      ST_READY     = 3'd4
   } seq_state_t;

   localparam int ICW1_IC4_BIT  = 0;
   localparam int ICW1_SNGL_BIT = 1;
   localparam int ICW1_ADI_BIT  = 2;
   localparam int ICW1_LTIM_BIT = 3;
   localparam int ICW1_MARK_BIT = 4;
   localparam int OCW_SEL_BIT   = 3;
   localparam int ICW4_WIDTH    = 5;

   // Low 'lines' bits set; the ICW3 bits beyond the wired cascade lines read as 0.
   function automatic logic [7:0] cascade_mask(input int lines);
      logic [7:0] m;
      m = '0;
      for (int i = 0; i < 8; i++) begin
         if (i < lines) m[i] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/initialization_command_word_sequencer_if.sv
// CPU write bus from the 8259A bus buffer into the control logic.
interface initialization_command_word_sequencer_if;
   logic       write_strobe;
   logic       address_a0;
   logic [7:0] internal_data_bus;

   modport master (
      output write_strobe,
      output address_a0,
      output internal_data_bus
   );

   modport slave (
      input write_strobe,
      input address_a0,
      input internal_data_bus
   );
endinterface

// File: rtl/initialization_command_word_sequencer.sv
// ICW1..ICW4 sequencer for the 8259A: decodes CPU writes, holds the
// initialization configuration and emits one-cycle OCW1/2/3 strobes once
// the sequence is complete.
//
//   state        | meaning
//   -------------+-------------------------------------------------
//   ST_UNINIT    | after reset, only ICW1 is acted on
//   ST_WAIT_ICW2 | ICW1 taken, next A0=1 write is the vector base
//   ST_WAIT_ICW3 | cascade mode, next A0=1 write is the ICW3 map
//   ST_WAIT_ICW4 | IC4 set, next A0=1 write is the mode word
//   ST_READY     | initialized, writes decode as OCW1/2/3
module initialization_command_word_sequencer
   import initialization_command_word_sequencer_pkg::*;
#(
   parameter int CASCADE_LINES = 8,
   parameter bit SUPPORT_ICW4  = 1'b1
) (
   input  logic                                   i_clock,
   input  logic                                   i_reset,
   initialization_command_word_sequencer_if.slave bus,
   output logic [10:0]                            o_interrupt_vector_address,
   output logic                                   o_level_or_edge_triggered_config,
   output logic                                   o_call_address_interval_4_or_8_config,
   output logic                                   o_single_or_cascade_config,
   output logic                                   o_set_icw4_config,
   output logic [7:0]                             o_cascade_device_config,
   output logic                                   o_special_fully_nest_config,
   output logic                                   o_buffered_mode_config,
   output logic                                   o_buffered_master_or_slave_config,
   output logic                                   o_auto_eoi_config,
   output logic                                   o_u8086_or_mcs80_config,
   output logic                                   o_initialization_start,
   output logic                                   o_initialization_complete,
   output logic                                   o_write_operation_control_word_1,
   output logic                                   o_write_operation_control_word_2,
   output logic                                   o_write_operation_control_word_3
);

   localparam logic [7:0] C_CASCADE_MASK = cascade_mask(CASCADE_LINES);

   seq_state_t            r_state;
   logic [10:0]           r_vector;
   logic                  r_ltim;
   logic                  r_adi;
   logic                  r_sngl;
   logic                  r_ic4;
   logic [7:0]            r_cascade;
   logic [ICW4_WIDTH-1:0] r_icw4;
   logic                  r_init_start;
   logic                  r_init_complete;
   logic                  r_ocw1;
   logic                  r_ocw2;
   logic                  r_ocw3;
   logic                  w_icw1;
   logic [7:0]            w_data;

   assign w_data = bus.internal_data_bus;
   assign w_icw1 = bus.write_strobe & ~bus.address_a0 & w_data[ICW1_MARK_BIT];

   // Sequence FSM and configuration registers; ICW1 restarts from any state.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state         <= ST_UNINIT;
         r_vector        <= '0;
         r_ltim          <= 1'b0;
         r_adi           <= 1'b0;
         r_sngl          <= 1'b0;
         r_ic4           <= 1'b0;
         r_cascade       <= '0;
         r_icw4          <= '0;
         r_init_start    <= 1'b0;
         r_init_complete <= 1'b0;
         r_ocw1          <= 1'b0;
         r_ocw2          <= 1'b0;
         r_ocw3          <= 1'b0;
      end else begin
         r_init_start <= 1'b0;
         r_ocw1       <= 1'b0;
         r_ocw2       <= 1'b0;
         r_ocw3       <= 1'b0;
         if (w_icw1) begin
            r_vector        <= {8'h00, w_data[7:5]};
            r_ltim          <= w_data[ICW1_LTIM_BIT];
            r_adi           <= w_data[ICW1_ADI_BIT];
            r_sngl          <= w_data[ICW1_SNGL_BIT];
            r_ic4           <= w_data[ICW1_IC4_BIT] & SUPPORT_ICW4;
            r_cascade       <= '0;
            r_icw4          <= '0;
            r_init_start    <= 1'b1;
            r_init_complete <= 1'b0;
            r_state         <= ST_WAIT_ICW2;
         end else if (bus.write_strobe) begin
            case (r_state)
               ST_WAIT_ICW2: begin
                  if (bus.address_a0) begin
                     r_vector[10:3] <= w_data;
                     if (!r_sngl) begin
                        r_state <= ST_WAIT_ICW3;
                     end else if (r_ic4) begin
                        r_state <= ST_WAIT_ICW4;
                     end else begin
                        r_state         <= ST_READY;
                        r_init_complete <= 1'b1;
                     end
                  end
               end
               ST_WAIT_ICW3: begin
                  if (bus.address_a0) begin
                     r_cascade <= w_data & C_CASCADE_MASK;
                     if (r_ic4) begin
                        r_state <= ST_WAIT_ICW4;
                     end else begin
                        r_state         <= ST_READY;
                        r_init_complete <= 1'b1;
                     end
                  end
               end
               ST_WAIT_ICW4: begin
                  if (bus.address_a0) begin
                     if (SUPPORT_ICW4) r_icw4 <= w_data[ICW4_WIDTH-1:0];
                     r_state         <= ST_READY;
                     r_init_complete <= 1'b1;
                  end
               end
               ST_READY: begin
                  // D4=1 with A0=0 was already taken as ICW1 above.
                  if (bus.address_a0)              r_ocw1 <= 1'b1;
                  else if (w_data[OCW_SEL_BIT])    r_ocw3 <= 1'b1;
                  else                             r_ocw2 <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   assign o_interrupt_vector_address            = r_vector;
   assign o_level_or_edge_triggered_config      = r_ltim;
   assign o_call_address_interval_4_or_8_config = r_adi;
   assign o_single_or_cascade_config            = r_sngl;
   assign o_set_icw4_config                     = r_ic4;
   assign o_cascade_device_config               = r_cascade;
   assign o_special_fully_nest_config           = r_icw4[4];
   assign o_buffered_mode_config                = r_icw4[3];
   assign o_buffered_master_or_slave_config     = r_icw4[2];
   assign o_auto_eoi_config                     = r_icw4[1];
   assign o_u8086_or_mcs80_config               = r_icw4[0];
   assign o_initialization_start                = r_init_start;
   assign o_initialization_complete             = r_init_complete;
   assign o_write_operation_control_word_1      = r_ocw1;
   assign o_write_operation_control_word_2      = r_ocw2;
   assign o_write_operation_control_word_3      = r_ocw3;

endmodule
